// File: rtl/button_conditioner.sv
// Button conditioner: two independent channels, each with a 2-flop
// synchronizer, a debounce FSM, a registered debounced level and a
// one-cycle press strobe.

module button_conditioner_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  typedef enum logic [2:0] {
    LOCKOUT,
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       sync;
  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             level_nx, pulse_nx;

  assign s = sync[1];

  // Two-flop synchronizer for the asynchronous raw button
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], raw};
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKOUT;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      pulse <= pulse_nx;
    end
  end

  // Debounce next-state, counter and output logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    pulse_nx = 1'b0;
    unique case (state)
      LOCKOUT: begin
        level_nx = 1'b0;
        if (s) begin
          cnt_nx = '0;
        end else if (cnt == LIMIT_M1) begin
          // the current low sample is the DEBOUNCE_CYCLES-th in a row
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      IDLE: begin
        level_nx = 1'b0;
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = ONE;
        end else begin
          cnt_nx = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == LIMIT) begin
          state_nx = HELD;
          cnt_nx   = '0;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      HELD: begin
        level_nx = 1'b1;
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == LIMIT) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          level_nx = 1'b0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = LOCKOUT;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic up_raw,
  input  logic down_raw,
  output logic up_level,
  output logic down_level,
  output logic up_pulse,
  output logic down_pulse
);

  button_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk  (clk),
    .rst  (rst),
    .raw  (up_raw),
    .level(up_level),
    .pulse(up_pulse)
  );

  button_conditioner_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_down (
    .clk  (clk),
    .rst  (rst),
    .raw  (down_raw),
    .level(down_level),
    .pulse(down_pulse)
  );

endmodule
